// File: rtl/instruction_memory_bank.sv
// instruction_memory_bank
//   Synchronous instruction store that sits between the program loader and the
//   fetch stage. Fetches have a registered 1-cycle read with valid, error and
//   stall-hold. A burst loader writes consecutive words from an auto-incrementing
//   pointer. An optional clear sequence zeroes the whole array after reset.
//
// Ports
//   clk          single clock, all logic on posedge
//   rst          synchronous active-high reset
//   fetch_req    fetch request
//   fetch_addr   fetch word address
//   fetch_stall  consumer stall, holds fetch outputs
//   fetch_data   registered instruction word
//   fetch_valid  fetch_data holds a completed fetch
//   fetch_err    completed fetch was out of range
//   load_start   enter LOAD, latch load_addr as the write pointer
//   load_addr    load start address
//   load_en      write load_data at the pointer this cycle
//   load_data    word to write
//   load_done    leave LOAD
//   load_count   words written since the last load_start
//   busy         high in CLEAR or LOAD
//
// State table
//   S_CLEAR | zeroing the array, one word per cycle
//   S_RUN   | fetches serviced, waiting for load_start
//   S_LOAD  | burst write through the load pointer
module instruction_memory_bank #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int DEPTH          = 2048,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_stall,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_valid,
  output logic                  fetch_err,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  load_en,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_done,
  output logic [ADDR_WIDTH-1:0] load_count,
  output logic                  busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic [IDX_W-1:0]      r_clear_ptr;
  logic [IDX_W-1:0]      r_load_ptr;
  logic [ADDR_WIDTH-1:0] r_load_count;
  logic [DATA_WIDTH-1:0] r_fetch_data;
  logic                  r_fetch_valid;
  logic                  r_fetch_err;

  logic                  w_busy;
  logic                  w_mem_we;
  logic [IDX_W-1:0]      w_mem_waddr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_fetch_take;
  logic                  w_load_write;
  logic                  w_fetch_in_range;
  logic [IDX_W-1:0]      w_load_ptr_start;
  logic [IDX_W-1:0]      w_load_ptr_inc;
  logic [IDX_W-1:0]      w_fetch_idx;

  // One extra bit so the compare still works when DEPTH == 2**ADDR_WIDTH.
  assign w_fetch_in_range = ({1'b0, fetch_addr} < (ADDR_WIDTH + 1)'(DEPTH));
  assign w_fetch_idx      = fetch_addr[IDX_W-1:0];
  assign w_load_ptr_start = IDX_W'(load_addr % DEPTH);
  assign w_load_ptr_inc   = (r_load_ptr == LAST_IDX) ? '0 : r_load_ptr + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_CLEAR: if (r_clear_ptr == LAST_IDX) w_state_next = S_RUN;
      S_RUN:   if (load_start) w_state_next = S_LOAD;
      S_LOAD:  if (!load_start && load_done) w_state_next = S_RUN;
      default: w_state_next = S_RUN;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_busy       = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_waddr  = '0;
    w_mem_wdata  = '0;
    w_fetch_take = 1'b0;
    w_load_write = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_busy      = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_waddr = r_clear_ptr;
      end
      S_RUN: begin
        // load_start wins over a same-cycle fetch; that fetch is dropped.
        w_fetch_take = fetch_req && !fetch_stall && !load_start;
      end
      S_LOAD: begin
        w_busy = 1'b1;
        // A re-latching load_start takes precedence over a same-cycle write.
        w_load_write = load_en && !load_start;
        w_mem_we     = w_load_write;
        w_mem_waddr  = r_load_ptr;
        w_mem_wdata  = load_data;
      end
      default: ;
    endcase
  end

  // Array write; reset aborts any write in progress.
  always_ff @(posedge clk) begin
    if (w_mem_we && !rst) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Pointers, counter and fetch result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clear_ptr   <= '0;
      r_load_ptr    <= '0;
      r_load_count  <= '0;
      r_fetch_data  <= '0;
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else begin
      if (r_state == S_CLEAR) begin
        r_clear_ptr <= (r_clear_ptr == LAST_IDX) ? '0 : r_clear_ptr + 1'b1;
      end

      if ((r_state == S_RUN || r_state == S_LOAD) && load_start) begin
        r_load_ptr   <= w_load_ptr_start;
        r_load_count <= '0;
      end else if (w_load_write) begin
        r_load_ptr <= w_load_ptr_inc;
        if (r_load_count != '1) begin
          r_load_count <= r_load_count + 1'b1;
        end
      end

      if (r_state != S_RUN || load_start) begin
        r_fetch_valid <= 1'b0;
        r_fetch_err   <= 1'b0;
      end else if (!fetch_stall) begin
        if (w_fetch_take) begin
          r_fetch_valid <= 1'b1;
          r_fetch_err   <= !w_fetch_in_range;
          r_fetch_data  <= w_fetch_in_range ? r_mem[w_fetch_idx] : '0;
        end else begin
          r_fetch_valid <= 1'b0;
          r_fetch_err   <= 1'b0;
        end
      end
    end
  end

  assign fetch_data  = r_fetch_data;
  assign fetch_valid = r_fetch_valid;
  assign fetch_err   = r_fetch_err;
  assign load_count  = r_load_count;
  assign busy        = w_busy;

endmodule

// File: tb/tb_instruction_memory_bank.sv
module tb_instruction_memory_bank;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_stall;
  logic [DW-1:0] fetch_data;
  logic          fetch_valid;
  logic          fetch_err;
  logic          load_start;
  logic [AW-1:0] load_addr;
  logic          load_en;
  logic [DW-1:0] load_data;
  logic          load_done;
  logic [AW-1:0] load_count;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0]   model [0:DEPTH-1];
  logic [DW+1:0]   sb [$];
  logic [DW+1:0]   exp_v;

  instruction_memory_bank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid), .fetch_err(fetch_err),
    .load_start(load_start), .load_addr(load_addr), .load_en(load_en),
    .load_data(load_data), .load_done(load_done), .load_count(load_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req   = 1'b0;
    fetch_addr  = '0;
    fetch_stall = 1'b0;
    load_start  = 1'b0;
    load_addr   = '0;
    load_en     = 1'b0;
    load_data   = '0;
    load_done   = 1'b0;
  endtask

  // Expected {valid, err, data} for a fetch of addr, from the bench's memory model.
  function automatic logic [DW+1:0] expect_fetch(input logic [AW-1:0] addr);
    if (int'(addr) >= DEPTH) return {1'b1, 1'b1, {DW{1'b0}}};
    return {1'b1, 1'b0, model[int'(addr)]};
  endfunction

  task automatic push_fetch(input logic [AW-1:0] addr);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    sb.push_back(expect_fetch(addr));
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    rst        = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 16'd5;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b1 || fetch_valid !== 1'b0 || fetch_err !== 1'b0 ||
        fetch_data !== '0 || load_count !== '0) begin
      failures++;
      $display("FAIL reset_state busy=%b valid=%b err=%b data=%h cnt=%0d want busy=1 valid=0 err=0 data=0 cnt=0",
               busy, fetch_valid, fetch_err, fetch_data, load_count);
    end
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      n++;
      if (fetch_valid !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL clear_valid cycle=%0d valid=%b want 0", n, fetch_valid);
      end
      tick();
    end
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL clear_length busy_cycles=%0d want %0d", n, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    checks++;
    if (fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_exit_valid valid=%b want 0", fetch_valid);
    end
    push_fetch(16'd5);
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({fetch_valid, fetch_err, fetch_data} !== exp_v) begin
      failures++;
      $display("FAIL first_fetch got=%h want=%h", {fetch_valid, fetch_err, fetch_data}, exp_v);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_load();
    load_start = 1'b1;
    load_addr  = 16'h0010;
    tick();
    load_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || load_count !== '0 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL load_entry busy=%b cnt=%0d valid=%b want busy=1 cnt=0 valid=0", busy, load_count, fetch_valid);
    end
    for (int i = 0; i < 4; i++) begin
      load_en   = 1'b1;
      load_data = 32'hA0 + 32'(i);
      model[16'h10 + i] = 32'hA0 + 32'(i);
      tick();
    end
    load_en   = 1'b0;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || load_count !== 16'd4) begin
      failures++;
      $display("FAIL load_done busy=%b cnt=%0d want busy=0 cnt=4", busy, load_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int a = 16'h10; a <= 16'h13; a++) begin
      push_fetch(AW'(a));
      tick();
      exp_v = sb.pop_front();
      checks++;
      if ({fetch_valid, fetch_err, fetch_data} !== exp_v) begin
        failures++;
        $display("FAIL b2b_fetch addr=%0h got=%h want=%h", a, {fetch_valid, fetch_err, fetch_data}, exp_v);
      end
    end
    fetch_req = 1'b0;
    tick();
    checks++;
    if (fetch_valid !== 1'b0 || fetch_err !== 1'b0 || fetch_data !== 32'hA3) begin
      failures++;
      $display("FAIL idle_hold valid=%b err=%b data=%h want valid=0 err=0 data=a3", fetch_valid, fetch_err, fetch_data);
    end
  endtask

  task automatic test_stall();
    push_fetch(16'h10);
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({fetch_valid, fetch_err, fetch_data} !== exp_v) begin
      failures++;
      $display("FAIL stall_pre got=%h want=%h", {fetch_valid, fetch_err, fetch_data}, exp_v);
    end
    fetch_stall = 1'b1;
    fetch_req   = 1'b1;
    fetch_addr  = 16'h11;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (fetch_valid !== 1'b1 || fetch_err !== 1'b0 || fetch_data !== 32'hA0) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d valid=%b data=%h want valid=1 data=a0", i, fetch_valid, fetch_data);
      end
    end
    fetch_stall = 1'b0;
    push_fetch(16'h11);
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({fetch_valid, fetch_err, fetch_data} !== exp_v) begin
      failures++;
      $display("FAIL stall_release got=%h want=%h", {fetch_valid, fetch_err, fetch_data}, exp_v);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_range_err();
    logic [AW-1:0] addrs [3];
    addrs[0] = 16'd2048;
    addrs[1] = 16'h0012;
    addrs[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      push_fetch(addrs[i]);
      tick();
      exp_v = sb.pop_front();
      checks++;
      if ({fetch_valid, fetch_err, fetch_data} !== exp_v) begin
        failures++;
        $display("FAIL range_fetch addr=%0d got=%h want=%h", addrs[i], {fetch_valid, fetch_err, fetch_data}, exp_v);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (fetch_err !== 1'b0 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL err_clear err=%b valid=%b want 0 0", fetch_err, fetch_valid);
    end
  endtask

  task automatic test_run_ignores();
    load_en   = 1'b1;
    load_done = 1'b1;
    load_data = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    checks++;
    if (busy !== 1'b0 || load_count !== 16'd4) begin
      failures++;
      $display("FAIL run_ignore_load busy=%b cnt=%0d want busy=0 cnt=4", busy, load_count);
    end
    push_fetch(16'h14);
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({fetch_valid, fetch_err, fetch_data} !== exp_v) begin
      failures++;
      $display("FAIL run_ignore_mem got=%h want=%h", {fetch_valid, fetch_err, fetch_data}, exp_v);
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    logic [AW-1:0] addrs [3];
    load_start = 1'b1;
    load_addr  = 16'd2046;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_en   = 1'b1;
      load_data = 32'(i + 1);
      model[(2046 + i) % DEPTH] = 32'(i + 1);
      tick();
    end
    load_en   = 1'b0;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    checks++;
    if (load_count !== 16'd3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL wrap_count cnt=%0d busy=%b want cnt=3 busy=0", load_count, busy);
    end
    addrs[0] = 16'd2046;
    addrs[1] = 16'd2047;
    addrs[2] = 16'd0;
    for (int i = 0; i < 3; i++) begin
      push_fetch(addrs[i]);
      tick();
      exp_v = sb.pop_front();
      checks++;
      if ({fetch_valid, fetch_err, fetch_data} !== exp_v) begin
        failures++;
        $display("FAIL wrap_fetch addr=%0d got=%h want=%h", addrs[i], {fetch_valid, fetch_err, fetch_data}, exp_v);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_load_done_same();
    // load_start with a same-cycle fetch: fetch is dropped
    fetch_req  = 1'b1;
    fetch_addr = 16'h10;
    load_start = 1'b1;
    load_addr  = 16'h0100;
    tick();
    idle_inputs();
    checks++;
    if (fetch_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_priority valid=%b busy=%b want valid=0 busy=1", fetch_valid, busy);
    end
    load_en   = 1'b1;
    load_done = 1'b1;
    load_data = 32'hDEAD_BEEF;
    model[16'h100] = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    checks++;
    if (busy !== 1'b0 || load_count !== 16'd1) begin
      failures++;
      $display("FAIL en_done_same busy=%b cnt=%0d want busy=0 cnt=1", busy, load_count);
    end
    push_fetch(16'h100);
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({fetch_valid, fetch_err, fetch_data} !== exp_v) begin
      failures++;
      $display("FAIL en_done_fetch got=%h want=%h", {fetch_valid, fetch_err, fetch_data}, exp_v);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_load();
    int n;
    load_start = 1'b1;
    load_addr  = 16'h0200;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_en   = 1'b1;
      load_data = 32'h5500 + 32'(i);
      tick();
    end
    load_en = 1'b0;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b1 || load_count !== '0 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_load_reset busy=%b cnt=%0d valid=%b want busy=1 cnt=0 valid=0", busy, load_count, fetch_valid);
    end
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      n++;
      tick();
    end
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL reclear_length busy_cycles=%0d want %0d", n, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    push_fetch(16'h0200);
    tick();
    push_fetch(16'h0010);
    exp_v = sb.pop_front();
    checks++;
    if ({fetch_valid, fetch_err, fetch_data} !== exp_v) begin
      failures++;
      $display("FAIL reclear_fetch0 got=%h want=%h", {fetch_valid, fetch_err, fetch_data}, exp_v);
    end
    tick();
    exp_v = sb.pop_front();
    checks++;
    if ({fetch_valid, fetch_err, fetch_data} !== exp_v) begin
      failures++;
      $display("FAIL reclear_fetch1 got=%h want=%h", {fetch_valid, fetch_err, fetch_data}, exp_v);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_load();
    test_back_to_back();
    test_stall();
    test_range_err();
    test_run_ignores();
    test_wrap();
    test_load_done_same();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_memory_bank.md
Name: instruction_memory_bank

Overview:
- Parametrised synchronous instruction store, successor to the combinational-read instruction SRAM.
- Fetch port has a registered 1-cycle read, a valid flag and stall hold.
- A burst loader port writes consecutive words with an auto-incrementing pointer.
- An optional post-reset clear sequence zeroes the array. Sits between the program loader/testbench and the fetch stage.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 16, width of fetch and load address ports.
- DEPTH, 2048, number of words; DEPTH <= 2^ADDR_WIDTH.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset before accepting fetches.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- fetch_req  input  1  fetch request, sampled on posedge.
- fetch_addr  input  ADDR_WIDTH  word address of the fetch.
- fetch_stall  input  1  consumer stall; holds fetch outputs.
- fetch_data  output  DATA_WIDTH  registered instruction word.
- fetch_valid  output  1  fetch_data holds a completed fetch.
- fetch_err  output  1  completed fetch was out of range (addr >= DEPTH).
- load_start  input  1  pulse: enter LOAD, latch load_addr as the pointer.
- load_addr  input  ADDR_WIDTH  load start address.
- load_en  input  1  write load_data at the pointer this cycle.
- load_data  input  DATA_WIDTH  word to write.
- load_done  input  1  pulse: leave LOAD.
- load_count  output  ADDR_WIDTH  words written since the last load_start.
- busy  output  1  high in CLEAR or LOAD.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- On reset:
  - state = CLEAR if CLEAR_ON_RESET, else RUN.
  - clear_ptr = 0, load pointer = 0, load_count = 0.
  - fetch_data = 0, fetch_valid = 0, fetch_err = 0.
  - busy = 1 if CLEAR_ON_RESET, else 0.
  - Array contents are not reset, except by the CLEAR sequence.
- CLEAR:
  - Each cycle writes 0 to mem[clear_ptr] and increments clear_ptr.
  - The cycle that writes index DEPTH-1 transitions to RUN.
  - busy stays high through that cycle and is low from the next cycle on; CLEAR lasts exactly DEPTH cycles.
  - fetch_req, load_start, load_en and load_done are ignored. fetch_valid stays 0.
- RUN, fetch:
  - If fetch_stall = 1: fetch_data, fetch_valid and fetch_err hold; fetch_req is ignored (not queued).
  - Else if fetch_req = 1: next cycle fetch_valid = 1.
    - In range: fetch_data = mem[fetch_addr], fetch_err = 0.
    - fetch_addr >= DEPTH: fetch_data = 0, fetch_err = 1.
  - Else: next cycle fetch_valid = 0 and fetch_err = 0; fetch_data holds.
  - Latency is exactly 1 cycle; back-to-back requests give one result per cycle.
- RUN, load entry:
  - load_start = 1 moves to LOAD next cycle: pointer = load_addr mod DEPTH, load_count = 0.
  - load_start has priority over fetch_req in the same cycle; that fetch is dropped and fetch_valid = 0 next cycle.
  - load_en and load_done in RUN are ignored.
- LOAD:
  - busy = 1, fetch_valid = 0, fetch_err = 0; fetch_req is ignored.
  - load_en = 1: mem[pointer] <= load_data; pointer increments and wraps DEPTH-1 -> 0; load_count increments (saturating at 2^ADDR_WIDTH-1).
  - load_done = 1: transition to RUN next cycle. If load_en is also 1 in that cycle, the write is performed first.
  - load_start in LOAD re-latches the pointer and zeroes load_count.
  - load_count holds its value after returning to RUN until the next load_start or reset.
- Reset mid-CLEAR or mid-LOAD: aborts immediately. Words already written stay written. CLEAR restarts from 0 if enabled.
- No read/write collision is possible: writes occur only in CLEAR and LOAD, reads only in RUN.

Test Plan:
- Reset with defaults, hold fetch_req = 1, addr = 5 -> busy = 1 for 2048 cycles, fetch_valid = 0 throughout; first RUN fetch returns fetch_data = 0, fetch_valid = 1 one cycle later.
- load_start with addr = 0x10, four load_en cycles writing 0xA0..0xA3, then load_done -> load_count = 4, busy falls. Fetches of 0x10..0x13 back-to-back return 0xA0..0xA3 on consecutive cycles.
- Fetch 0x10, then assert fetch_stall for 3 cycles while fetch_req = 1 with addr = 0x11 -> fetch_data holds 0xA0 and valid stays 1; after release, 0xA1 appears 1 cycle after the unstalled request.
- Fetch addr = 2048 -> fetch_valid = 1, fetch_err = 1, fetch_data = 0. Next fetch of 0x12 returns fetch_err = 0.
- Load at 2046 with three writes 0x1, 0x2, 0x3 -> mem[2046] = 0x1, mem[2047] = 0x2, mem[0] = 0x3; load_count = 3.
- load_en and load_done in the same cycle -> word written, RUN next cycle. rst asserted mid-LOAD -> CLEAR restarts and busy = 1 for 2048 cycles; load_count = 0.
